block_sync_rx_32b: RTL and testbench
====================================

// Module: block_sync_rx_32b
// PURPOSE
// - 10GBASE-R RX block-lock controller (IEEE 802.3 cl.49 lock FSM) for the 32b RX path.
// - Checks the 2-bit sync header that arrives with each even word of a 66b block.
// - Issues slip pulses to the RX gearbox until headers align, then asserts block_lock.
// - Gates the descrambler word enable so only locked data advances the scrambler state.
// PARAMETERS
// - SH_CNT_MAX    64  headers per test window
// - SH_INVLD_MAX  16  invalid headers per window that drop lock
// - SLIP_WAIT     32  clk cycles after a slip pulse before header checks resume (>=1)
// PORTS
// - clk            in   1   RX word clock; the only clock
// - rst_n          in   1   asynchronous, active-low reset
// - hdr_in         in   2   sync header from gearbox, meaningful when din_en & evenin
// - din_en         in   1   gearbox word-valid strobe
// - evenin         in   1   1 = current word is the even (header-bearing) half of a block
// - slip           out  1   one-cycle pulse: gearbox shifts alignment by one bit
// - block_lock     out  1   1 = header alignment achieved
// - descr_en       out  1   din_en & block_lock, combinational; drives descrambler din_en
// - sh_invld_cnt   out  5   invalid-header count in current window, status only
// BEHAVIOUR
// - Reset (rst_n=0, any cycle, mid-slip included): state=LOCK_INIT, slip=0, block_lock=0,
//   sh_cnt=0, sh_invld_cnt=0, slip-wait counter=0; all outputs low after reset.
// - Header sample event: din_en=1 & evenin=1. Valid header: hdr_in = 2'b01 or 2'b10.
//   Invalid header: 2'b00 or 2'b11. Words with evenin=0 or din_en=0 are ignored.
// - States: LOCK_INIT, RESET_CNT, TEST_SH, SLIP_WAIT_ST.
//   - LOCK_INIT: next cycle -> RESET_CNT; block_lock=0.
//   - RESET_CNT: sh_cnt=0, sh_invld_cnt=0; next cycle -> TEST_SH.
//     Any sample event during this cycle is dropped.
//   - TEST_SH, on sample event, with sh_cnt' = sh_cnt+1:
//     - valid header, sh_cnt'<SH_CNT_MAX: stay in TEST_SH.
//     - valid header, sh_cnt'==SH_CNT_MAX: if sh_invld_cnt==0, set block_lock=1.
//       Lock is never cleared here. -> RESET_CNT.
//     - invalid header, sh_invld_cnt'=sh_invld_cnt+1:
//       - if !block_lock or sh_invld_cnt'==SH_INVLD_MAX: block_lock=0, slip=1 for one cycle,
//         -> SLIP_WAIT_ST.
//       - else if sh_cnt'==SH_CNT_MAX: -> RESET_CNT.
//       - else stay in TEST_SH.
//   - SLIP_WAIT_ST: counts SLIP_WAIT cycles from the slip pulse, ignoring sample events,
//     then -> RESET_CNT.
// - Timing: slip and block_lock are registered and change the cycle after the deciding
//   sample event. descr_en has 0 added latency.
// - Counter widths: sh_cnt is 7 bits, sh_invld_cnt is 5 bits; neither can wrap. Both saturate
//   by construction, because the window ends at SH_CNT_MAX and slip fires at SH_INVLD_MAX.
// - din_en stalls (din_en=0) freeze the header counters. SLIP_WAIT counts clk cycles, not words.
// STRUCTURE
// - Shared package rx10g_pkg: state enum t_bsync_state; SH_VALID_01/SH_VALID_10 constants;
//   function sh_is_valid(logic [1:0]).
// - Single always_ff FSM plus counters; no sub-module needed.
// - The top level wires descr_en to the descrambler din_en and slip to the gearbox.
// TESTING
// - 64 headers 2'b01 (one per even word, din_en=1) -> block_lock rises 1 cycle after 64th; slip=0 throughout.
// - Unlocked, 1st header 2'b11 -> slip pulse exactly 1 cycle, then no checks for 32 cycles,
//   then counting restarts from 0.
// - Locked, 15 invalid + 49 valid in one window -> lock held, counters reset at window end;
//   16th invalid instead -> block_lock=0 and slip pulse on the same cycle.
// - Locked, window of 63 valid + 1 invalid -> stays locked, sh_invld_cnt=1 then 0 after RESET_CNT.
// - rst_n low mid SLIP_WAIT_ST and mid TEST_SH -> all outputs 0 immediately (async);
//   relock needs a full 64 clean headers.
// - Odd words carrying 2'b00 and din_en=0 gaps -> no effect on counters or lock;
//   descr_en == din_en & block_lock every cycle.

Source files
------------

// File: rtl/rx10g_pkg.sv
// rtl/rx10g_pkg.sv - shared 10GBASE-R RX types, constants and header helpers
package rx10g_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT    = 2'd0,
    RESET_CNT    = 2'd1,
    TEST_SH      = 2'd2,
    SLIP_WAIT_ST = 2'd3
  } t_bsync_state;

  localparam logic [1:0] SH_VALID_01 = 2'b01;
  localparam logic [1:0] SH_VALID_10 = 2'b10;

  localparam int SH_CNT_MAX_DEF   = 64;
  localparam int SH_INVLD_MAX_DEF = 16;
  localparam int SLIP_WAIT_DEF    = 32;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_VALID_01) || (sh == SH_VALID_10);
  endfunction

endpackage

// File: rtl/block_sync_rx_32b.sv
// rtl/block_sync_rx_32b.sv - 10GBASE-R RX block-lock FSM for the 32b gearbox path
module block_sync_rx_32b
  import rx10g_pkg::*;
#(
  parameter int SH_CNT_MAX   = SH_CNT_MAX_DEF,
  parameter int SH_INVLD_MAX = SH_INVLD_MAX_DEF,
  parameter int SLIP_WAIT    = SLIP_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] hdr_in,
  input  logic       din_en,
  input  logic       evenin,
  output logic       slip,
  output logic       block_lock,
  output logic       descr_en,
  output logic [4:0] sh_invld_cnt
);

  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

  t_bsync_state      r_state;
  logic [6:0]        r_sh_cnt;
  logic [4:0]        r_invld;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_slip;
  logic              r_lock;

  logic       w_sample;
  logic       w_hdr_ok;
  logic [6:0] w_sh_cnt_nxt;
  logic [4:0] w_invld_nxt;
  logic       w_win_end;
  logic       w_invld_lim;
  logic       w_wait_done;

  assign w_sample     = din_en & evenin;
  assign w_hdr_ok     = sh_is_valid(hdr_in);
  assign w_sh_cnt_nxt = r_sh_cnt + 7'd1;
  assign w_invld_nxt  = r_invld + 5'd1;
  assign w_win_end    = (w_sh_cnt_nxt == 7'(SH_CNT_MAX));
  assign w_invld_lim  = (w_invld_nxt == 5'(SH_INVLD_MAX));
  assign w_wait_done  = (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOCK_INIT;
      r_sh_cnt   <= '0;
      r_invld    <= '0;
      r_wait_cnt <= '0;
      r_slip     <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_slip <= 1'b0;
      case (r_state)
        LOCK_INIT: begin
          r_lock  <= 1'b0;
          r_state <= RESET_CNT;
        end
        RESET_CNT: begin
          r_sh_cnt <= '0;
          r_invld  <= '0;
          r_state  <= TEST_SH;
        end
        TEST_SH: begin
          if (w_sample) begin
            r_sh_cnt <= w_sh_cnt_nxt;
            if (w_hdr_ok) begin
              // A clean window grants lock; a dirty one never revokes it here.
              if (w_win_end) begin
                if (r_invld == 5'd0) r_lock <= 1'b1;
                r_state <= RESET_CNT;
              end
            end else begin
              r_invld <= w_invld_nxt;
              if (!r_lock || w_invld_lim) begin
                r_lock     <= 1'b0;
                r_slip     <= 1'b1;
                r_wait_cnt <= '0;
                r_state    <= SLIP_WAIT_ST;
              end else if (w_win_end) begin
                r_state <= RESET_CNT;
              end
            end
          end
        end
        SLIP_WAIT_ST: begin
          // Gives the gearbox time to settle on the new bit alignment.
          if (w_wait_done) r_state <= RESET_CNT;
          else             r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
        default: r_state <= LOCK_INIT;
      endcase
    end
  end

  assign slip         = r_slip;
  assign block_lock   = r_lock;
  assign sh_invld_cnt = r_invld;
  assign descr_en     = din_en & r_lock;

endmodule

// File: tb/tb_block_sync_rx_32b.sv
// tb/tb_block_sync_rx_32b.sv - directed self-checking bench for block_sync_rx_32b
module tb_block_sync_rx_32b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] hdr_in = 2'b00;
  logic       din_en = 1'b0;
  logic       evenin = 1'b0;
  logic       slip;
  logic       block_lock;
  logic       descr_en;
  logic [4:0] sh_invld_cnt;

  int   n_chk = 0;
  int   n_pass = 0;
  logic cur_lock = 1'b0;

  typedef struct {
    logic       en;
    logic       ev;
    logic [1:0] hdr;
    logic       e_slip;
    logic       e_lock;
    logic [4:0] e_inv;
  } vec_t;

  vec_t tbl[7];

  block_sync_rx_32b dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_in       (hdr_in),
    .din_en       (din_en),
    .evenin       (evenin),
    .slip         (slip),
    .block_lock   (block_lock),
    .descr_en     (descr_en),
    .sh_invld_cnt (sh_invld_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic en, input logic ev, input logic [1:0] hdr,
                      input logic e_slip, input logic e_lock, input logic [4:0] e_inv,
                      input string name);
    @(negedge clk);
    din_en = en;
    evenin = ev;
    hdr_in = hdr;
    #1;
    check({name, "_descr_en"}, 32'(descr_en), 32'(en & cur_lock));
    @(posedge clk);
    #1;
    check({name, "_slip"}, 32'(slip), 32'(e_slip));
    check({name, "_lock"}, 32'(block_lock), 32'(e_lock));
    check({name, "_inv"}, 32'(sh_invld_cnt), 32'(e_inv));
    cur_lock = e_lock;
  endtask

  task automatic wait_slip_done(input logic [4:0] v);
    for (int i = 1; i <= 33; i++)
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, (i <= 32) ? v : 5'd0, "slipwait");
  endtask

  task automatic window(input int lo, input int hi, input logic lock_in);
    int   nbad;
    logic lk;
    logic bad;
    logic e_lock;
    nbad = 0;
    lk = lock_in;
    for (int k = 1; k <= 64; k++) begin
      bad = (k >= lo) && (k <= hi);
      if (bad) nbad++;
      if (bad && (!lk || nbad == 16)) begin
        step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'(nbad), "win_slip");
        return;
      end
      e_lock = lk | ((k == 64) && (nbad == 0));
      step(1'b1, 1'b1, bad ? 2'b11 : 2'b01, 1'b0, e_lock, 5'(nbad), "win_even");
      lk = e_lock;
      step(1'b1, 1'b0, 2'b00, 1'b0, lk, (k == 64) ? 5'd0 : 5'(nbad), "win_odd");
      if (k % 16 == 5)
        step(1'b0, 1'b1, 2'b11, 1'b0, lk, 5'(nbad), "win_gap");
    end
  endtask

  task automatic async_reset(input string name);
    din_en = 1'b1;
    evenin = 1'b1;
    hdr_in = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "_slip"}, 32'(slip), 32'd0);
    check({name, "_lock"}, 32'(block_lock), 32'd0);
    check({name, "_inv"}, 32'(sh_invld_cnt), 32'd0);
    check({name, "_descr_en"}, 32'(descr_en), 32'd0);
    cur_lock = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, "post_rst_init");
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, "post_rst_rcnt");
  endtask

  initial begin
    // en ev hdr slip lock inv; first two land in LOCK_INIT and RESET_CNT
    tbl[0] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0};
    tbl[3] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0};
    tbl[4] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0};
    tbl[5] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'd1};
    tbl[6] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd1};

    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_slip", 32'(slip), 32'd0);
    check("rst_lock", 32'(block_lock), 32'd0);
    check("rst_inv", 32'(sh_invld_cnt), 32'd0);
    check("rst_descr_en", 32'(descr_en), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      step(tbl[i].en, tbl[i].ev, tbl[i].hdr, tbl[i].e_slip, tbl[i].e_lock, tbl[i].e_inv,
           $sformatf("tbl%0d", i));

    // Invalid headers inside the 32-cycle wait must be ignored
    for (int i = 2; i <= 32; i++)
      step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 5'd1, "wait_ignore");
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, "wait_rcnt");
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'd1, "wait_reslip");
    wait_slip_done(5'd1);

    window(100, 0, 1'b0);
    window(1, 15, 1'b1);
    window(64, 64, 1'b1);
    window(1, 16, 1'b1);
    async_reset("rst_slipwait");

    window(100, 0, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 5'd0, "pre_rst_v1");
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 5'd0, "pre_rst_v2");
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 5'd1, "pre_rst_inv");
    async_reset("rst_testsh");
    window(100, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
